// File: rtl/regfile_mp.sv
// regfile_mp: register file with two write ports, two registered-address read ports and per-register pending (scoreboard) bits
//   clk, rst            : clock, asynchronous active-high reset
//   raddr0_/raddr1_     : read addresses, registered at the edge
//   rdata0/rdata1       : data at the registered read addresses
//   busy0/busy1         : pending bit at the registered read addresses
//   wen*/waddr*/wdata*  : write ports; port 1 wins on an address collision
//   claim/claim_addr    : set pending on a register; beats a same-cycle write's clear
module regfile_mp #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr0_,
  input  logic [AW-1:0]    raddr1_,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             busy0,
  output logic             busy1,
  input  logic             wen0,
  input  logic             wen1,
  input  logic [AW-1:0]    waddr0,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             claim,
  input  logic [AW-1:0]    claim_addr
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [AW-1:0]    r_ra0, r_ra1;
  logic             w_we0, w_we1, w_cl, w_z0, w_z1;
  // a hardwired-zero register 0 swallows every write and claim aimed at it
  assign w_we0 = wen0 && !(ZERO_R0 != 0 && waddr0 == '0);
  assign w_we1 = wen1 && !(ZERO_R0 != 0 && waddr1 == '0);
  assign w_cl  = claim && !(ZERO_R0 != 0 && claim_addr == '0);
  assign w_z0  = ZERO_R0 != 0 && r_ra0 == '0;
  assign w_z1  = ZERO_R0 != 0 && r_ra1 == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra0  <= '0;
      r_ra1  <= '0;
      r_pend <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ra0 <= raddr0_;
      r_ra1 <= raddr1_;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we1 && waddr1 == AW'(i)) r_mem[i] <= wdata1;
        else if (w_we0 && waddr0 == AW'(i)) r_mem[i] <= wdata0;
        r_pend[i] <= (w_cl && claim_addr == AW'(i)) ? 1'b1 :
                     ((w_we0 && waddr0 == AW'(i)) || (w_we1 && waddr1 == AW'(i))) ? 1'b0 : r_pend[i];
      end
    end
  end
  // reads follow the registered address combinationally, so a write committed
  // on the same edge that captured the address is already visible
  always_comb begin
    rdata0 = w_z0 ? '0 : r_mem[r_ra0];
    rdata1 = w_z1 ? '0 : r_mem[r_ra1];
    busy0  = w_z0 ? 1'b0 : r_pend[r_ra0];
    busy1  = w_z1 ? 1'b0 : r_pend[r_ra1];
  end
endmodule
